pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the hand-written per-stage latches with one block that carries a packed stage payload, a valid bit and a multi-cycle scratch vector (MADD/DIV partial state) across the stage boundary. It adds flush, selectable scratch-hold policy and saturating per-stage performance counters. It is instantiated once per boundary (IF/ID … MEM/WB) and driven by the central stall controller's stall vector.

---
 rtl/pipe_pkg.sv | 83 ++++++++
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the five-stage pipeline: stall vector width, stage
// indices, payload/scratch field layout and the stage-register operation decode.
package pipe_pkg;

  localparam int PIPE_STALL_W = 6;

  // Stage indices, also the bit positions in the stall vector
  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  localparam logic [5:0] OP_NOP = 6'b000000;

  // IF/ID boundary payload: fetched PC and instruction word
  localparam int IFID_PC_LSB   = 0;
  localparam int IFID_PC_W     = 32;
  localparam int IFID_INST_LSB = 32;
  localparam int IFID_INST_W   = 32;

  // ID/EX, EX/MEM and MEM/WB boundaries share one layout; fields a stage
  // does not use yet are carried as zero. Opcode and wreg sit at the bottom
  // so an all-zero payload is a NOP that writes no register.
  localparam int PL_OPCODE_LSB   = 0;
  localparam int PL_OPCODE_W     = 6;
  localparam int PL_WREG_BIT     = 6;
  localparam int PL_WADDR_LSB    = 7;
  localparam int PL_WADDR_W      = 5;
  localparam int PL_WDATA_LSB    = 12;
  localparam int PL_WDATA_W      = 32;
  localparam int PL_HI_LSB       = 44;
  localparam int PL_HI_W         = 32;
  localparam int PL_LO_LSB       = 76;
  localparam int PL_LO_W         = 32;
  localparam int PL_CP0_WE_BIT   = 108;
  localparam int PL_CP0_ADDR_LSB = 109;
  localparam int PL_CP0_ADDR_W   = 5;
  localparam int PL_CP0_DATA_LSB = 114;
  localparam int PL_CP0_DATA_W   = 32;
  localparam int PL_TAG_LSB      = 146;
  localparam int PL_TAG_W        = 14;
  localparam int PL_W            = 160;

  // Iterative-op scratch (MADD/MSUB accumulation, DIV partial state)
  localparam int SC_HILO_LSB      = 0;
  localparam int SC_HILO_W        = 64;
  localparam int SC_MADD_STAT_LSB = 64;
  localparam int SC_MADD_STAT_W   = 2;
  localparam int SC_DIV_STAT_LSB  = 66;
  localparam int SC_DIV_STAT_W    = 2;
  localparam int SC_REM_LSB       = 68;
  localparam int SC_REM_W         = 16;
  localparam int SC_QUO_LSB       = 84;
  localparam int SC_QUO_W         = 16;
  localparam int SC_SHIFT_CNT_LSB = 100;
  localparam int SC_SHIFT_CNT_W   = 4;
  localparam int SC_W             = 104;

  // What the stage register does on a given edge
  typedef enum logic [2:0] {
    STG_RESET   = 3'd0,
    STG_FLUSH   = 3'd1,
    STG_BUBBLE  = 3'd2,
    STG_ADVANCE = 3'd3,
    STG_HOLD    = 3'd4
  } stg_op_e;

  // rst > flush > bubble > advance > hold. su=0 always advances, so the
  // illegal su=0/sd=1 pattern lands on the advance path.
  function automatic stg_op_e stg_op_decode(input logic rst, input logic flush,
                                            input logic su, input logic sd);
    stg_op_e op;
    if (rst)            op = STG_RESET;
    else if (flush)     op = STG_FLUSH;
    else if (su && !sd) op = STG_BUBBLE;
    else if (!su)       op = STG_ADVANCE;
    else                op = STG_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; at all-ones the increment is dropped
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload, valid and iterative-op scratch
// across one stage boundary, with flush, bubble/hold handling and
// saturating bubble/hold/flush event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W       = 160,
  parameter int                   SCRATCH_W       = 104,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD     = '0,
  parameter int                   STALL_W         = pipe_pkg::PIPE_STALL_W,
  parameter int                   STAGE_IDX       = pipe_pkg::STAGE_EX,
  parameter bit                   CAPTURE_ON_HOLD = 1'b1,
  parameter int                   CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall_i,
  input  logic                 flush_i,
  input  logic                 cnt_clr_i,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_valid,
  input  logic [SCRATCH_W-1:0] in_scratch,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid,
  output logic [SCRATCH_W-1:0] out_scratch,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     hold_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic    su;
  logic    sd;
  logic    unused_stall;
  stg_op_e op;

  assign su = stall_i[STAGE_IDX];

  // The last stage has no consumer, so it can never be held from below
  generate
    if (STAGE_IDX == STALL_W - 1) begin : g_last_stage
      assign sd = 1'b0;
    end else begin : g_mid_stage
      assign sd = stall_i[STAGE_IDX+1];
    end
  endgenerate

  // Only two stall bits matter at this boundary
  assign unused_stall = ^stall_i;

  // Per-edge operation select
  always_comb begin
    op = stg_op_decode(rst, flush_i, su, sd);
  end

  // Payload, valid and scratch update
  always_ff @(posedge clk) begin
    case (op)
      STG_RESET, STG_FLUSH: begin
        // Zeroing scratch aborts any MADD/DIV in flight; it restarts upstream
        out_payload <= NOP_PAYLOAD;
        out_valid   <= 1'b0;
        out_scratch <= '0;
      end
      STG_BUBBLE: begin
        // Upstream iterates in place: feed its partial state back each cycle
        out_payload <= NOP_PAYLOAD;
        out_valid   <= 1'b0;
        out_scratch <= in_scratch;
      end
      STG_ADVANCE: begin
        out_payload <= in_payload;
        out_valid   <= in_valid;
        out_scratch <= '0;
      end
      default: begin
        if (CAPTURE_ON_HOLD) begin
          out_scratch <= in_scratch;
        end
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_i),
    .inc   (op == STG_BUBBLE),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_i),
    .inc   (op == STG_HOLD),
    .count (hold_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_i),
    .inc   (op == STG_FLUSH),
    .count (flush_cnt)
  );

  // The stall controller must never stall the consumer while the producer runs
  a_legal_stall : assert property (@(posedge clk) disable iff (rst) !(sd && !su));

endmodule
